fx2_slave_fifo_responder: RTL and testbench
===========================================

// Module: fx2_slave_fifo_responder
// PURPOSE
//  FX2-side end of the slave-FIFO link: bench/emulation responder for the FPGA-side FX2 master.
//  Host side feeds EP2 (PC->FPGA commands) and drains EP4/EP5 (FPGA->PC data, length) as packets.
//  FX2 side decodes SLRD/SLWR/PKTEND/FIFOADR/SLOE, drives FX2_FD and the full/empty flags.
// PARAMETERS
//  EP2_DEPTH  16   bytes in EP2 OUT FIFO (power of 2)
//  EP4_DEPTH  512  entries in EP4 IN FIFO (power of 2)
//  EP5_DEPTH  8    entries in EP5 IN FIFO (power of 2)
//  PKT_SIZE   512  EP4 auto-commit size in bytes (<= EP4_DEPTH)
// PORTS
//  FX2_CLK        in   1  interface clock; all logic on rising edge
//  RESET_N        in   1  asynchronous, active-low reset
//  FX2_FD         io   8  data bus; driven only when SLOE active and FIFOADR=00
//  FX2_SLRD       in   1  read strobe, active low
//  FX2_SLWR       in   1  write strobe, active low
//  FX2_flags      out  3  [0] EP2 not empty, [1] EP3 not empty (always 0), [2] EP4 not full
//  FX2_PA_2       in   1  SLOE, active low
//  FX2_PA_3       in   1  ignored (held high by FPGA)
//  FX2_PA_4       in   1  FIFOADR[0]
//  FX2_PA_5       in   1  FIFOADR[1]
//  FX2_PA_6       in   1  PKTEND, active low
//  FX2_PA_7       out  1  EP5 not full
//  HOST_CMD       in   8  byte to push into EP2
//  HOST_CMD_VALID in   1  push request
//  HOST_CMD_READY out  1  EP2 not full
//  HOST_IN_DATA   out  8  IN byte to host (0 on ZLP)
//  HOST_IN_VALID  out  1  committed byte available
//  HOST_IN_READY  in   1  host accepts beat
//  HOST_IN_EP     out  1  0=EP4, 1=EP5
//  HOST_IN_LAST   out  1  last beat of packet
//  HOST_IN_ZLP    out  1  zero-length packet beat (LAST also 1)
//  UNDERFLOW_ERR  out  1  sticky: SLRD on empty EP2
//  OVERFLOW_ERR   out  1  sticky: SLWR on full EP4/EP5, or SLWR/SLRD to an invalid address
//  CONFLICT_ERR   out  1  sticky: SLWR low while SLOE low (bus contention)
// BEHAVIOUR
//  Reset: FIFOs and commit pointers cleared; FX2_flags=3'b100, FX2_PA_7=1, FD hi-Z;
//   HOST_CMD_READY=0 while RESET_N low, 1 after; HOST_IN_* = 0; errors = 0. Mid-packet reset discards all.
//  Addr {PA_5,PA_4}: 00=EP2, 10=EP4, 11=EP5, 01=invalid (strobes set OVERFLOW_ERR, no effect).
//  FD = EP2 head, combinational, when PA_2=0 and addr=00 (0x00 if empty); else hi-Z.
//  Read: edge with SLRD=0, addr=00, EP2 non-empty -> pop; empty -> UNDERFLOW_ERR, no pop.
//  Write: edge with SLWR=0, addr 10/11 -> push {zlp=0,last=0,FD}; full -> drop, OVERFLOW_ERR.
//  Entries 10 bits {zlp,last,data}; occupancy counts committed + uncommitted entries.
//  PKTEND: edge with PA_6=0, addr 10/11 -> commit all uncommitted bytes of that EP, mark newest last.
//   No uncommitted bytes -> push one ZLP entry {1,1,0} (needs a free slot, else OVERFLOW_ERR).
//   Same-edge SLWR+PKTEND: byte is pushed first, then included in the commit.
//  EP4 auto-commit: uncommitted count reaches PKT_SIZE -> commit, last on that byte.
//  Flags from registered counts: visible the cycle after the edge that changes them.
//   [0]=EP2 count!=0; [2]=EP4 count<EP4_DEPTH; PA_7=EP5 count<EP5_DEPTH.
//  Host push and FX2 pop of EP2 on the same edge both take effect; count unchanged.
//  Host drain: committed entries only; beat transfers on VALID&&READY. Packet-atomic; at packet
//   boundary EP5 has priority over EP4. VALID/DATA/EP/LAST/ZLP stable until accepted.
//  Pointers wrap modulo depth; counts are log2(DEPTH)+1 bits wide.
// TESTING
//  Host pushes 0x13 -> flags[0]=1 next cycle; addr 00, PA_2=0, SLRD=0 one cycle -> FD=0x13, flags[0]=0 after.
//  SLRD pulse on empty EP2 -> UNDERFLOW_ERR=1, FD=0x00, counts unchanged.
//  64 EP4 writes 0x00..0x3F, then PKTEND -> no host beat before PKTEND; 64 beats EP=0, LAST on 0x3F.
//  EP5 writes 0x12,0x34+PKTEND during EP4 drain -> EP5 beats 0x12,0x34(LAST) only after EP4 LAST.
//  Fill EP4 to EP4_DEPTH without PKTEND -> auto-commit at PKT_SIZE, flags[2]=0; extra write -> OVERFLOW_ERR.
//  PKTEND on EP4 with nothing uncommitted -> single beat ZLP=1, LAST=1, DATA=0; then reset mid-drain -> all empty, FD hi-Z.

Source files
------------

// File: rtl/fx2_slave_fifo_responder.sv
// FX2-side slave-FIFO responder: EP2 OUT FIFO fed by the host, EP4/EP5 IN FIFOs with
// packet commit (PKTEND / auto-commit) drained by the host one packet at a time.

module fx2_in_ep #(
  parameter int DEPTH = 8,
  parameter int AUTO  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  input  logic       i_pktend,
  input  logic       i_pop,
  output logic [9:0] o_head,
  output logic       o_avail,
  output logic       o_full,
  output logic       o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]       r_mem [DEPTH];
  logic [DEPTH-1:0] r_last;
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt, r_ucnt;

  logic          w_full, w_push_d, w_zlp, w_commit, w_push;
  logic [CW-1:0] w_ucnt_a;

  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_push_d = i_wr && !w_full;
  assign w_ucnt_a = r_ucnt + CW'(w_push_d);
  // a same-edge write is counted before PKTEND decides between commit and ZLP
  assign w_zlp    = i_pktend && (w_ucnt_a == '0) && !w_full;
  assign w_commit = (i_pktend && (w_ucnt_a != '0)) ||
                    ((AUTO != 0) && (w_ucnt_a == CW'(AUTO)));
  assign w_push   = w_push_d || w_zlp;

  assign o_full  = w_full;
  assign o_ovf   = (i_wr && w_full) || (i_pktend && (w_ucnt_a == '0) && w_full);
  assign o_avail = (r_cnt != r_ucnt);
  assign o_head  = {r_mem[r_rp][8], r_last[r_rp], r_mem[r_rp][7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ucnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(i_pop);
      r_ucnt <= (w_commit || w_zlp) ? '0 : w_ucnt_a;
    end
  end

  // commit without a same-edge push marks the previously written entry as last
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp]  <= {w_zlp, w_zlp ? 8'h00 : i_data};
      r_last[r_wp] <= w_zlp || w_commit;
    end else if (w_commit) begin
      r_last[r_wp - AW'(1)] <= 1'b1;
    end
  end
endmodule

module fx2_slave_fifo_responder #(
  parameter int EP2_DEPTH = 16,
  parameter int EP4_DEPTH = 512,
  parameter int EP5_DEPTH = 8,
  parameter int PKT_SIZE  = 512
) (
  input  logic       FX2_CLK,
  input  logic       RESET_N,
  inout  wire  [7:0] FX2_FD,
  input  logic       FX2_SLRD,
  input  logic       FX2_SLWR,
  output logic [2:0] FX2_flags,
  input  logic       FX2_PA_2,
  input  logic       FX2_PA_3,
  input  logic       FX2_PA_4,
  input  logic       FX2_PA_5,
  input  logic       FX2_PA_6,
  output logic       FX2_PA_7,
  input  logic [7:0] HOST_CMD,
  input  logic       HOST_CMD_VALID,
  output logic       HOST_CMD_READY,
  output logic [7:0] HOST_IN_DATA,
  output logic       HOST_IN_VALID,
  input  logic       HOST_IN_READY,
  output logic       HOST_IN_EP,
  output logic       HOST_IN_LAST,
  output logic       HOST_IN_ZLP,
  output logic       UNDERFLOW_ERR,
  output logic       OVERFLOW_ERR,
  output logic       CONFLICT_ERR
);
  localparam int A2 = $clog2(EP2_DEPTH);
  localparam int C2 = A2 + 1;

  logic [1:0] w_addr;
  logic       w_rd, w_wr, w_pe, w_unused;
  assign w_addr   = {FX2_PA_5, FX2_PA_4};
  assign w_rd     = !FX2_SLRD;
  assign w_wr     = !FX2_SLWR;
  assign w_pe     = !FX2_PA_6;
  assign w_unused = FX2_PA_3;

  // EP2: host -> FX2 command bytes
  logic [7:0]    r_ep2_mem [EP2_DEPTH];
  logic [A2-1:0] r_ep2_wp, r_ep2_rp;
  logic [C2-1:0] r_ep2_cnt;
  logic          w_ep2_empty, w_ep2_full, w_h_push, w_rd2, w_pop2, w_fd_oe;
  logic [7:0]    w_fd_out;

  assign w_ep2_empty    = (r_ep2_cnt == '0);
  assign w_ep2_full     = (r_ep2_cnt == C2'(EP2_DEPTH));
  assign HOST_CMD_READY = RESET_N && !w_ep2_full;
  assign w_h_push       = HOST_CMD_VALID && HOST_CMD_READY;
  assign w_rd2          = w_rd && (w_addr == 2'b00);
  assign w_pop2         = w_rd2 && !w_ep2_empty;
  assign w_fd_oe        = !FX2_PA_2 && (w_addr == 2'b00);
  assign w_fd_out       = w_ep2_empty ? 8'h00 : r_ep2_mem[r_ep2_rp];
  assign FX2_FD         = w_fd_oe ? w_fd_out : 8'hzz;

  always_ff @(posedge FX2_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ep2_wp  <= '0;
      r_ep2_rp  <= '0;
      r_ep2_cnt <= '0;
    end else begin
      if (w_h_push) r_ep2_wp <= r_ep2_wp + A2'(1);
      if (w_pop2)   r_ep2_rp <= r_ep2_rp + A2'(1);
      r_ep2_cnt <= r_ep2_cnt + C2'(w_h_push) - C2'(w_pop2);
    end
  end

  always_ff @(posedge FX2_CLK) begin
    if (w_h_push) r_ep2_mem[r_ep2_wp] <= HOST_CMD;
  end

  // EP4 / EP5: FX2 -> host
  logic [9:0] w_head4, w_head5, w_head;
  logic       w_av4, w_av5, w_full4, w_full5, w_ovf4, w_ovf5;
  logic       w_pop4, w_pop5, w_sel, w_valid, w_acc;

  fx2_in_ep #(.DEPTH(EP4_DEPTH), .AUTO(PKT_SIZE)) u_ep4 (
    .clk(FX2_CLK), .rst_n(RESET_N),
    .i_wr(w_wr && (w_addr == 2'b10)), .i_data(FX2_FD),
    .i_pktend(w_pe && (w_addr == 2'b10)), .i_pop(w_pop4),
    .o_head(w_head4), .o_avail(w_av4), .o_full(w_full4), .o_ovf(w_ovf4)
  );

  fx2_in_ep #(.DEPTH(EP5_DEPTH), .AUTO(0)) u_ep5 (
    .clk(FX2_CLK), .rst_n(RESET_N),
    .i_wr(w_wr && (w_addr == 2'b11)), .i_data(FX2_FD),
    .i_pktend(w_pe && (w_addr == 2'b11)), .i_pop(w_pop5),
    .o_head(w_head5), .o_avail(w_av5), .o_full(w_full5), .o_ovf(w_ovf5)
  );

  assign FX2_flags = {!w_full4, 1'b0, !w_ep2_empty};
  assign FX2_PA_7  = !w_full5;

  // the endpoint is locked from the first presented beat until its LAST is accepted,
  // so a later EP5 commit cannot change a beat already on offer
  logic r_busy, r_sel;
  assign w_sel   = r_busy ? r_sel : w_av5;
  assign w_valid = r_busy ? (r_sel ? w_av5 : w_av4) : (w_av4 || w_av5);
  assign w_head  = w_sel ? w_head5 : w_head4;
  assign w_acc   = w_valid && HOST_IN_READY;
  assign w_pop4  = w_acc && !w_sel;
  assign w_pop5  = w_acc && w_sel;

  assign HOST_IN_VALID = w_valid;
  assign HOST_IN_DATA  = w_valid ? w_head[7:0] : 8'h00;
  assign HOST_IN_LAST  = w_valid && w_head[8];
  assign HOST_IN_ZLP   = w_valid && w_head[9];
  assign HOST_IN_EP    = w_valid && w_sel;

  always_ff @(posedge FX2_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_busy <= 1'b0;
      r_sel  <= 1'b0;
    end else if (w_valid) begin
      r_busy <= !(w_acc && w_head[8]);
      r_sel  <= w_sel;
    end
  end

  logic r_unf, r_ovf, r_cfl;
  assign UNDERFLOW_ERR = r_unf;
  assign OVERFLOW_ERR  = r_ovf;
  assign CONFLICT_ERR  = r_cfl;

  always_ff @(posedge FX2_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_unf <= 1'b0;
      r_ovf <= 1'b0;
      r_cfl <= 1'b0;
    end else begin
      if (w_rd2 && w_ep2_empty) r_unf <= 1'b1;
      if (((w_rd || w_wr) && (w_addr == 2'b01)) || w_ovf4 || w_ovf5) r_ovf <= 1'b1;
      if (w_wr && !FX2_PA_2) r_cfl <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Scenario bench for fx2_slave_fifo_responder: EP2 reads, EP4/EP5 packets, auto-commit,
// ZLP, reset mid-drain and error flags, with a scoreboard of expected host beats.

module tb_fx2_slave_fifo_responder;
  logic       FX2_CLK = 1'b0;
  logic       RESET_N;
  wire  [7:0] FX2_FD;
  logic       FX2_SLRD, FX2_SLWR, FX2_PA_2, FX2_PA_3, FX2_PA_4, FX2_PA_5, FX2_PA_6;
  logic [2:0] FX2_flags;
  logic       FX2_PA_7;
  logic [7:0] HOST_CMD;
  logic       HOST_CMD_VALID, HOST_CMD_READY;
  logic [7:0] HOST_IN_DATA;
  logic       HOST_IN_VALID, HOST_IN_READY, HOST_IN_EP, HOST_IN_LAST, HOST_IN_ZLP;
  logic       UNDERFLOW_ERR, OVERFLOW_ERR, CONFLICT_ERR;

  logic [7:0] tb_fd;
  logic       tb_fd_oe;
  assign FX2_FD = tb_fd_oe ? tb_fd : 8'hzz;

  always #5 FX2_CLK = ~FX2_CLK;

  fx2_slave_fifo_responder dut (
    .FX2_CLK(FX2_CLK), .RESET_N(RESET_N), .FX2_FD(FX2_FD),
    .FX2_SLRD(FX2_SLRD), .FX2_SLWR(FX2_SLWR), .FX2_flags(FX2_flags),
    .FX2_PA_2(FX2_PA_2), .FX2_PA_3(FX2_PA_3), .FX2_PA_4(FX2_PA_4),
    .FX2_PA_5(FX2_PA_5), .FX2_PA_6(FX2_PA_6), .FX2_PA_7(FX2_PA_7),
    .HOST_CMD(HOST_CMD), .HOST_CMD_VALID(HOST_CMD_VALID), .HOST_CMD_READY(HOST_CMD_READY),
    .HOST_IN_DATA(HOST_IN_DATA), .HOST_IN_VALID(HOST_IN_VALID), .HOST_IN_READY(HOST_IN_READY),
    .HOST_IN_EP(HOST_IN_EP), .HOST_IN_LAST(HOST_IN_LAST), .HOST_IN_ZLP(HOST_IN_ZLP),
    .UNDERFLOW_ERR(UNDERFLOW_ERR), .OVERFLOW_ERR(OVERFLOW_ERR), .CONFLICT_ERR(CONFLICT_ERR)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [10:0] sb_q[$];   // {ep, zlp, last, data}
  logic [7:0]  ep2_q[$];

  // one FX2 strobe cycle: signals set at a negedge, edge acts, released at the next negedge
  task automatic fx2_op(input logic [1:0] a, input logic wr, input logic rd,
                        input logic pe, input logic [7:0] d);
    @(negedge FX2_CLK);
    {FX2_PA_5, FX2_PA_4} = a;
    tb_fd = d; tb_fd_oe = wr;
    FX2_SLWR = !wr; FX2_SLRD = !rd; FX2_PA_6 = !pe;
    @(negedge FX2_CLK);
    FX2_SLWR = 1'b1; FX2_SLRD = 1'b1; FX2_PA_6 = 1'b1; tb_fd_oe = 1'b0;
  endtask

  task automatic host_push(input logic [7:0] d);
    @(negedge FX2_CLK);
    HOST_CMD = d; HOST_CMD_VALID = 1'b1;
    ep2_q.push_back(d);
    @(negedge FX2_CLK);
    HOST_CMD_VALID = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    logic [10:0] act, exp;
    @(negedge FX2_CLK);
    HOST_IN_READY = 1'b1;
    while (1) begin
      if (HOST_IN_VALID) begin
        act = {HOST_IN_EP, HOST_IN_ZLP, HOST_IN_LAST, HOST_IN_DATA};
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_extra: got %h, expected no beat", act);
        end else begin
          exp = sb_q.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL drain_beat %0d: got %h, expected %h", got, act, exp);
          end
        end
        got++;
      end
      if (got >= n || cyc >= budget) break;
      @(negedge FX2_CLK);
      cyc++;
    end
    @(posedge FX2_CLK);
    #1 HOST_IN_READY = 1'b0;
    if (got < n) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d beats, expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge FX2_CLK);
    n_tests++; if (FX2_flags !== 3'b100) begin n_fail++; $display("FAIL rst_flags: got %b, expected 100", FX2_flags); end
    n_tests++; if (FX2_PA_7 !== 1'b1) begin n_fail++; $display("FAIL rst_pa7: got %b, expected 1", FX2_PA_7); end
    n_tests++; if (HOST_CMD_READY !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b, expected 0", HOST_CMD_READY); end
    n_tests++; if ({HOST_IN_VALID, HOST_IN_DATA, HOST_IN_LAST, HOST_IN_ZLP, HOST_IN_EP} !== 12'h0) begin
      n_fail++; $display("FAIL rst_host_in: got %b%h%b%b%b, expected zeros", HOST_IN_VALID, HOST_IN_DATA, HOST_IN_LAST, HOST_IN_ZLP, HOST_IN_EP); end
    n_tests++; if ({UNDERFLOW_ERR, OVERFLOW_ERR, CONFLICT_ERR} !== 3'b000) begin
      n_fail++; $display("FAIL rst_errs: got %b, expected 000", {UNDERFLOW_ERR, OVERFLOW_ERR, CONFLICT_ERR}); end
    RESET_N = 1'b1;
    @(negedge FX2_CLK);
    n_tests++; if (HOST_CMD_READY !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_ready: got %b, expected 1", HOST_CMD_READY); end
  endtask

  task automatic test_ep2();
    logic [7:0] exp;
    host_push(8'h13);
    n_tests++; if (FX2_flags[0] !== 1'b1) begin n_fail++; $display("FAIL ep2_flag_set: got %b, expected 1", FX2_flags[0]); end
    @(negedge FX2_CLK);
    {FX2_PA_5, FX2_PA_4} = 2'b00; FX2_PA_2 = 1'b0;
    #1;
    exp = ep2_q.pop_front();
    n_tests++; if (FX2_FD !== exp) begin n_fail++; $display("FAIL ep2_fd_head: got %h, expected %h", FX2_FD, exp); end
    fx2_op(2'b00, 1'b0, 1'b1, 1'b0, 8'h00);
    n_tests++; if (FX2_flags[0] !== 1'b0) begin n_fail++; $display("FAIL ep2_flag_clr: got %b, expected 0", FX2_flags[0]); end
    n_tests++; if (FX2_FD !== 8'h00) begin n_fail++; $display("FAIL ep2_fd_empty: got %h, expected 00", FX2_FD); end
    n_tests++; if (UNDERFLOW_ERR !== 1'b0) begin n_fail++; $display("FAIL ep2_no_unf: got %b, expected 0", UNDERFLOW_ERR); end
    fx2_op(2'b00, 1'b0, 1'b1, 1'b0, 8'h00);
    n_tests++; if (UNDERFLOW_ERR !== 1'b1) begin n_fail++; $display("FAIL ep2_unf: got %b, expected 1", UNDERFLOW_ERR); end
    n_tests++; if ({FX2_flags[0], FX2_FD} !== 9'h000) begin n_fail++; $display("FAIL ep2_unf_state: got %b/%h, expected 0/00", FX2_flags[0], FX2_FD); end
    // host push and FX2 pop on the same edge
    host_push(8'h21);
    @(negedge FX2_CLK);
    HOST_CMD = 8'h22; HOST_CMD_VALID = 1'b1; ep2_q.push_back(8'h22);
    FX2_SLRD = 1'b0;
    exp = ep2_q.pop_front();
    #1;
    n_tests++; if (FX2_FD !== exp) begin n_fail++; $display("FAIL ep2_same_edge_head: got %h, expected %h", FX2_FD, exp); end
    @(negedge FX2_CLK);
    HOST_CMD_VALID = 1'b0; FX2_SLRD = 1'b1;
    #1;
    n_tests++; if ({FX2_flags[0], FX2_FD} !== {1'b1, ep2_q[0]}) begin
      n_fail++; $display("FAIL ep2_same_edge: got %b/%h, expected 1/%h", FX2_flags[0], FX2_FD, ep2_q[0]); end
    fx2_op(2'b00, 1'b0, 1'b1, 1'b0, 8'h00);
    void'(ep2_q.pop_front());
    n_tests++; if (FX2_flags[0] !== 1'b0) begin n_fail++; $display("FAIL ep2_drained: got %b, expected 0", FX2_flags[0]); end
    FX2_PA_2 = 1'b1;
  endtask

  task automatic test_ep4_packet();
    for (int i = 0; i < 64; i++) begin
      fx2_op(2'b10, 1'b1, 1'b0, 1'b0, 8'(i));
      sb_q.push_back({1'b0, 1'b0, (i == 63), 8'(i)});
    end
    n_tests++; if (HOST_IN_VALID !== 1'b0) begin n_fail++; $display("FAIL ep4_precommit_valid: got %b, expected 0", HOST_IN_VALID); end
    fx2_op(2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
    n_tests++; if (HOST_IN_VALID !== 1'b1) begin n_fail++; $display("FAIL ep4_commit_valid: got %b, expected 1", HOST_IN_VALID); end
    fork
      drain(67, 400);
      begin
        fx2_op(2'b11, 1'b1, 1'b0, 1'b0, 8'h12); sb_q.push_back({1'b1, 1'b0, 1'b0, 8'h12});
        fx2_op(2'b11, 1'b1, 1'b0, 1'b1, 8'h34); sb_q.push_back({1'b1, 1'b0, 1'b1, 8'h34});
        fx2_op(2'b10, 1'b1, 1'b0, 1'b1, 8'hA0); sb_q.push_back({1'b0, 1'b0, 1'b1, 8'hA0});
      end
    join
    n_tests++; if ({OVERFLOW_ERR, CONFLICT_ERR, HOST_IN_VALID} !== 3'b000) begin
      n_fail++; $display("FAIL ep4_pkt_end_state: got %b, expected 000", {OVERFLOW_ERR, CONFLICT_ERR, HOST_IN_VALID}); end
  endtask

  task automatic test_ep5_full();
    for (int i = 0; i < 8; i++) begin
      fx2_op(2'b11, 1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
      sb_q.push_back({1'b1, 1'b0, (i == 7), 8'(8'h50 + i)});
    end
    n_tests++; if (FX2_PA_7 !== 1'b0) begin n_fail++; $display("FAIL ep5_full_flag: got %b, expected 0", FX2_PA_7); end
    fx2_op(2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
    drain(8, 40);
    n_tests++; if ({FX2_PA_7, OVERFLOW_ERR} !== 2'b10) begin
      n_fail++; $display("FAIL ep5_after_drain: got %b, expected 10", {FX2_PA_7, OVERFLOW_ERR}); end
  endtask

  task automatic test_ep4_fill();
    for (int i = 0; i < 512; i++) begin
      fx2_op(2'b10, 1'b1, 1'b0, 1'b0, 8'(i * 3));
      sb_q.push_back({1'b0, 1'b0, (i == 511), 8'(i * 3)});
      if (i == 510) begin
        n_tests++; if ({FX2_flags[2], HOST_IN_VALID} !== 2'b10) begin
          n_fail++; $display("FAIL fill_pre: got %b, expected 10", {FX2_flags[2], HOST_IN_VALID}); end
      end
    end
    n_tests++; if ({FX2_flags[2], HOST_IN_VALID, OVERFLOW_ERR} !== 3'b010) begin
      n_fail++; $display("FAIL fill_full: got %b, expected 010", {FX2_flags[2], HOST_IN_VALID, OVERFLOW_ERR}); end
    fx2_op(2'b10, 1'b1, 1'b0, 1'b0, 8'hEE);
    n_tests++; if (OVERFLOW_ERR !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b, expected 1", OVERFLOW_ERR); end
    drain(512, 700);
    n_tests++; if ({FX2_flags[2], HOST_IN_VALID} !== 2'b10) begin
      n_fail++; $display("FAIL fill_drained: got %b, expected 10", {FX2_flags[2], HOST_IN_VALID}); end
  endtask

  task automatic test_zlp_reset();
    fx2_op(2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
    sb_q.push_back({1'b0, 1'b1, 1'b1, 8'h00});
    drain(1, 20);
    for (int i = 0; i < 4; i++) begin
      fx2_op(2'b10, 1'b1, 1'b0, (i == 3), 8'(8'hC0 + i));
      sb_q.push_back({1'b0, 1'b0, (i == 3), 8'(8'hC0 + i)});
    end
    drain(2, 20);
    @(negedge FX2_CLK);
    RESET_N = 1'b0;
    sb_q.delete();
    tb_fd = 8'h5A; tb_fd_oe = 1'b1; FX2_PA_2 = 1'b1;
    #1;
    n_tests++; if ({HOST_IN_VALID, FX2_flags, FX2_PA_7, HOST_CMD_READY} !== 6'b010010) begin
      n_fail++; $display("FAIL midreset_state: got %b, expected 010010", {HOST_IN_VALID, FX2_flags, FX2_PA_7, HOST_CMD_READY}); end
    n_tests++; if ({UNDERFLOW_ERR, OVERFLOW_ERR, CONFLICT_ERR} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_errs: got %b, expected 000", {UNDERFLOW_ERR, OVERFLOW_ERR, CONFLICT_ERR}); end
    n_tests++; if (FX2_FD !== 8'h5A) begin n_fail++; $display("FAIL midreset_fd_hiz: got %h, expected 5a", FX2_FD); end
    tb_fd_oe = 1'b0;
    repeat (2) @(negedge FX2_CLK);
    RESET_N = 1'b1;
    HOST_IN_READY = 1'b1;
    repeat (3) @(negedge FX2_CLK);
    n_tests++; if ({HOST_IN_VALID, HOST_CMD_READY} !== 2'b01) begin
      n_fail++; $display("FAIL postreset_empty: got %b, expected 01", {HOST_IN_VALID, HOST_CMD_READY}); end
    HOST_IN_READY = 1'b0;
  endtask

  task automatic test_errors();
    fx2_op(2'b01, 1'b1, 1'b0, 1'b0, 8'h77);
    n_tests++; if ({OVERFLOW_ERR, FX2_PA_7, FX2_flags, CONFLICT_ERR} !== 6'b111000) begin
      n_fail++; $display("FAIL bad_addr: got %b, expected 111000", {OVERFLOW_ERR, FX2_PA_7, FX2_flags, CONFLICT_ERR}); end
    @(negedge FX2_CLK);
    FX2_PA_2 = 1'b0;
    fx2_op(2'b10, 1'b1, 1'b0, 1'b0, 8'h66);
    FX2_PA_2 = 1'b1;
    n_tests++; if ({CONFLICT_ERR, UNDERFLOW_ERR} !== 2'b10) begin
      n_fail++; $display("FAIL conflict: got %b, expected 10", {CONFLICT_ERR, UNDERFLOW_ERR}); end
  endtask

  initial begin
    RESET_N = 1'b0;
    FX2_SLRD = 1'b1; FX2_SLWR = 1'b1; FX2_PA_2 = 1'b1; FX2_PA_3 = 1'b1;
    FX2_PA_4 = 1'b0; FX2_PA_5 = 1'b0; FX2_PA_6 = 1'b1;
    HOST_CMD = 8'h00; HOST_CMD_VALID = 1'b0; HOST_IN_READY = 1'b0;
    tb_fd = 8'h00; tb_fd_oe = 1'b0;
    test_reset();
    test_ep2();
    test_ep4_packet();
    test_ep5_full();
    test_ep4_fill();
    test_zlp_reset();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
